// File: rtl/sound_latch.sv
// 68k <-> Z80 sound command latch with a reply byte, edge-detected bus events.
// Define SOUND_LATCH_FIFO_EN to replace the single command latch with a 4-entry FIFO.
module sound_latch (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       m68k_latch_cs,
  input  logic       m68k_lds_n,
  input  logic [7:0] m68k_din,
  input  logic       m68k_sound_cs,
  output logic [7:0] m68k_dout,
  input  logic       z80_latch_cs,
  input  logic       z80_rd_n,
  input  logic       z80_wr_n,
  input  logic [7:0] z80_din,
  output logic [7:0] z80_dout,
  output logic       z80_int_n,
  output logic       cmd_pending,
  output logic       reply_valid,
  output logic       overrun
);

  logic       cmd_wr_s, cmd_rd_s, rep_wr_s, rep_rd_s;
  logic       cmd_wr_ev_s, cmd_rd_ev_s, rep_wr_ev_s, rep_rd_ev_s;
  logic       init_q, init_d;
  logic       cmd_wr_prev_q, cmd_wr_prev_d, rep_wr_prev_q, rep_wr_prev_d;
  logic       cmd_rd_prev_q, cmd_rd_prev_d, rep_rd_prev_q, rep_rd_prev_d;
  logic       cmd_rd_arm_q, cmd_rd_arm_d, rep_rd_arm_q, rep_rd_arm_d;
  logic [7:0] reply_q, reply_d;
  logic       reply_valid_q, reply_valid_d;
  logic       overrun_q, overrun_d;
  logic       cmd_pending_q, z80_int_n_q;
  logic [7:0] z80_dout_q;
  logic       pending_s;
  logic [7:0] head_s;

  assign cmd_wr_s = m68k_latch_cs & ~m68k_lds_n;
  assign cmd_rd_s = z80_latch_cs & ~z80_rd_n;
  assign rep_wr_s = z80_latch_cs & ~z80_wr_n;
  assign rep_rd_s = m68k_sound_cs;

  // Edge detection; a falling-edge detector only arms after it has seen its select rise,
  // so an access straddling reset release never produces an end event.
  always_comb begin
    init_d        = 1'b1;
    cmd_wr_prev_d = cmd_wr_s;
    rep_wr_prev_d = rep_wr_s;
    cmd_rd_prev_d = cmd_rd_s;
    rep_rd_prev_d = rep_rd_s;
    cmd_rd_arm_d  = cmd_rd_s & (cmd_rd_arm_q | (init_q & ~cmd_rd_prev_q));
    rep_rd_arm_d  = rep_rd_s & (rep_rd_arm_q | (init_q & ~rep_rd_prev_q));
    cmd_wr_ev_s   = init_q & cmd_wr_s & ~cmd_wr_prev_q;
    rep_wr_ev_s   = init_q & rep_wr_s & ~rep_wr_prev_q;
    cmd_rd_ev_s   = cmd_rd_arm_q & ~cmd_rd_s;
    rep_rd_ev_s   = rep_rd_arm_q & ~rep_rd_s;
  end

  // Reply register: a new byte wins over a simultaneous read end.
  always_comb begin
    reply_d       = reply_q;
    reply_valid_d = reply_valid_q;
    if (rep_wr_ev_s) begin
      reply_d       = z80_din;
      reply_valid_d = 1'b1;
    end else if (rep_rd_ev_s) begin
      reply_valid_d = 1'b0;
    end else begin
      reply_valid_d = reply_valid_q;
    end
  end

`ifdef SOUND_LATCH_FIFO_EN
  logic [7:0] mem_q [4];
  logic [7:0] mem_d [4];
  logic [1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [2:0] count_q, count_d;
  logic       do_wr_s, do_rd_s;

  // FIFO next state; a full FIFO still accepts a write paired with a read.
  always_comb begin
    mem_d     = mem_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    do_rd_s   = cmd_rd_ev_s & (count_q != 3'd0);
    do_wr_s   = cmd_wr_ev_s & ((count_q != 3'd4) | do_rd_s);
    overrun_d = overrun_q | (cmd_wr_ev_s & ~do_wr_s);
    if (do_wr_s) begin
      mem_d[wr_ptr_q] = m68k_din;
      wr_ptr_d        = wr_ptr_q + 2'd1;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (do_rd_s) begin
      rd_ptr_d = rd_ptr_q + 2'd1;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({do_wr_s, do_rd_s})
      2'b10:   count_d = count_q + 3'd1;
      2'b01:   count_d = count_q - 3'd1;
      default: count_d = count_q;
    endcase
    pending_s = (count_q != 3'd0);
    head_s    = pending_s ? mem_q[rd_ptr_q] : z80_dout_q;
  end

  // FIFO storage and pointers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem_q    <= '{default: 8'h00};
      wr_ptr_q <= 2'd0;
      rd_ptr_q <= 2'd0;
      count_q  <= 3'd0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end
`else
  logic [7:0] cmd_byte_q, cmd_byte_d;
  logic       cmd_full_q, cmd_full_d;
  logic       do_rd_s;

  // Single latch: a write over an unread byte overwrites it and flags the loss.
  always_comb begin
    cmd_byte_d = cmd_byte_q;
    cmd_full_d = cmd_full_q;
    overrun_d  = overrun_q;
    do_rd_s    = cmd_rd_ev_s & cmd_full_q;
    if (cmd_wr_ev_s) begin
      cmd_byte_d = m68k_din;
      cmd_full_d = 1'b1;
      overrun_d  = overrun_q | (cmd_full_q & ~do_rd_s);
    end else if (do_rd_s) begin
      cmd_full_d = 1'b0;
    end else begin
      cmd_full_d = cmd_full_q;
    end
    pending_s = cmd_full_q;
    head_s    = cmd_byte_q;
  end

  // Command latch storage.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cmd_byte_q <= 8'h00;
      cmd_full_q <= 1'b0;
    end else begin
      cmd_byte_q <= cmd_byte_d;
      cmd_full_q <= cmd_full_d;
    end
  end
`endif

  // Edge registers, reply path and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      init_q        <= 1'b0;
      cmd_wr_prev_q <= 1'b0;
      rep_wr_prev_q <= 1'b0;
      cmd_rd_prev_q <= 1'b0;
      rep_rd_prev_q <= 1'b0;
      cmd_rd_arm_q  <= 1'b0;
      rep_rd_arm_q  <= 1'b0;
      reply_q       <= 8'h00;
      reply_valid_q <= 1'b0;
      overrun_q     <= 1'b0;
      cmd_pending_q <= 1'b0;
      z80_int_n_q   <= 1'b1;
      z80_dout_q    <= 8'h00;
    end else begin
      init_q        <= init_d;
      cmd_wr_prev_q <= cmd_wr_prev_d;
      rep_wr_prev_q <= rep_wr_prev_d;
      cmd_rd_prev_q <= cmd_rd_prev_d;
      rep_rd_prev_q <= rep_rd_prev_d;
      cmd_rd_arm_q  <= cmd_rd_arm_d;
      rep_rd_arm_q  <= rep_rd_arm_d;
      reply_q       <= reply_d;
      reply_valid_q <= reply_valid_d;
      overrun_q     <= overrun_d;
      cmd_pending_q <= pending_s;
      z80_int_n_q   <= ~pending_s;
      z80_dout_q    <= head_s;
    end
  end

  assign m68k_dout   = reply_q;
  assign reply_valid = reply_valid_q;
  assign overrun     = overrun_q;
  assign cmd_pending = cmd_pending_q;
  assign z80_int_n   = z80_int_n_q;
  assign z80_dout    = z80_dout_q;

endmodule

// File: tb/tb_sound_latch.sv
// Directed self-checking bench for sound_latch; expectations follow SOUND_LATCH_FIFO_EN.
module tb_sound_latch;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       m68k_latch_cs, m68k_lds_n, m68k_sound_cs;
  logic [7:0] m68k_din, m68k_dout;
  logic       z80_latch_cs, z80_rd_n, z80_wr_n;
  logic [7:0] z80_din, z80_dout;
  logic       z80_int_n, cmd_pending, reply_valid, overrun;

  int total = 0;
  int bad   = 0;

  sound_latch dut (
    .clk(clk), .reset_n(reset_n),
    .m68k_latch_cs(m68k_latch_cs), .m68k_lds_n(m68k_lds_n), .m68k_din(m68k_din),
    .m68k_sound_cs(m68k_sound_cs), .m68k_dout(m68k_dout),
    .z80_latch_cs(z80_latch_cs), .z80_rd_n(z80_rd_n), .z80_wr_n(z80_wr_n),
    .z80_din(z80_din), .z80_dout(z80_dout), .z80_int_n(z80_int_n),
    .cmd_pending(cmd_pending), .reply_valid(reply_valid), .overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic m68k_write(input logic [7:0] b, input int hold);
    @(negedge clk);
    m68k_din = b; m68k_latch_cs = 1'b1; m68k_lds_n = 1'b0;
    repeat (hold) @(negedge clk);
    m68k_latch_cs = 1'b0; m68k_lds_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic z80_read(input string tag, input logic [7:0] exp, input int hold);
    @(negedge clk);
    z80_latch_cs = 1'b1; z80_rd_n = 1'b0;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check_eq(tag, z80_dout, exp);
    end
    z80_latch_cs = 1'b0; z80_rd_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic z80_write(input logic [7:0] b);
    @(negedge clk);
    z80_din = b; z80_latch_cs = 1'b1; z80_wr_n = 1'b0;
    repeat (2) @(negedge clk);
    z80_latch_cs = 1'b0; z80_wr_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    reset_n = 1'b0;
    m68k_latch_cs = 1'b0; m68k_lds_n = 1'b1; m68k_din = 8'h00; m68k_sound_cs = 1'b0;
    z80_latch_cs = 1'b0; z80_rd_n = 1'b1; z80_wr_n = 1'b1; z80_din = 8'h00;
    repeat (3) @(negedge clk);
    check_eq("rst_z80_dout", z80_dout, 8'h00);
    check_eq("rst_m68k_dout", m68k_dout, 8'h00);
    check_eq("rst_int_n", 8'(z80_int_n), 8'h01);
    check_eq("rst_pending", 8'(cmd_pending), 8'h00);
    check_eq("rst_reply_valid", 8'(reply_valid), 8'h00);
    check_eq("rst_overrun", 8'(overrun), 8'h00);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);

    // 68k write held 6 clocks, outputs one clock after detection
    @(negedge clk);
    m68k_din = 8'h5A; m68k_latch_cs = 1'b1; m68k_lds_n = 1'b0;
    @(negedge clk);
    check_eq("wr_lat_pending0", 8'(cmd_pending), 8'h00);
    @(negedge clk);
    check_eq("wr_pending", 8'(cmd_pending), 8'h01);
    check_eq("wr_int_n", 8'(z80_int_n), 8'h00);
    check_eq("wr_dout", z80_dout, 8'h5A);
    repeat (4) @(negedge clk);
    m68k_latch_cs = 1'b0; m68k_lds_n = 1'b1;
    repeat (2) @(negedge clk);
    check_eq("wr_one_event_ovr", 8'(overrun), 8'h00);

    // Z80 read held 4 clocks
    z80_read("rd_stable", 8'h5A, 4);
    check_eq("rd_pending", 8'(cmd_pending), 8'h00);
    check_eq("rd_int_n", 8'(z80_int_n), 8'h01);

    // read with nothing pending changes nothing
    z80_read("empty_rd", 8'h5A, 2);
    check_eq("empty_rd_dout", z80_dout, 8'h5A);
    check_eq("empty_rd_pending", 8'(cmd_pending), 8'h00);

    // reply path
    z80_write(8'hC3);
    check_eq("rep_valid", 8'(reply_valid), 8'h01);
    @(negedge clk);
    m68k_sound_cs = 1'b1;
    repeat (2) @(negedge clk);
    check_eq("rep_dout", m68k_dout, 8'hC3);
    check_eq("rep_valid_rd", 8'(reply_valid), 8'h01);
    m68k_sound_cs = 1'b0;
    @(negedge clk);
    check_eq("rep_valid_clr", 8'(reply_valid), 8'h00);

    // simultaneous reply write and reply read end
    @(negedge clk);
    m68k_sound_cs = 1'b1;
    repeat (2) @(negedge clk);
    m68k_sound_cs = 1'b0;
    z80_din = 8'h99; z80_latch_cs = 1'b1; z80_wr_n = 1'b0;
    @(negedge clk);
    check_eq("rep_same_valid", 8'(reply_valid), 8'h01);
    check_eq("rep_same_dout", m68k_dout, 8'h99);
    z80_latch_cs = 1'b0; z80_wr_n = 1'b1;
    repeat (2) @(negedge clk);

    // simultaneous cmd write and cmd read end
    m68k_write(8'h11, 2);
    check_eq("same_pre_dout", z80_dout, 8'h11);
    @(negedge clk);
    z80_latch_cs = 1'b1; z80_rd_n = 1'b0;
    repeat (2) @(negedge clk);
    z80_latch_cs = 1'b0; z80_rd_n = 1'b1;
    m68k_din = 8'h22; m68k_latch_cs = 1'b1; m68k_lds_n = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("same_pending", 8'(cmd_pending), 8'h01);
    check_eq("same_dout", z80_dout, 8'h22);
    check_eq("same_overrun", 8'(overrun), 8'h00);
    m68k_latch_cs = 1'b0; m68k_lds_n = 1'b1;
    repeat (2) @(negedge clk);
    z80_read("same_drain", 8'h22, 2);
    check_eq("same_drain_pending", 8'(cmd_pending), 8'h00);

    // five writes into the command path
    for (int i = 1; i <= 5; i++) m68k_write(8'(i), 2);
    check_eq("ovr_set", 8'(overrun), 8'h01);
    check_eq("ovr_pending", 8'(cmd_pending), 8'h01);
`ifdef SOUND_LATCH_FIFO_EN
    check_eq("fifo_head", z80_dout, 8'h01);
    for (int i = 1; i <= 4; i++) z80_read("fifo_rd", 8'(i), 2);
    check_eq("fifo_empty", 8'(cmd_pending), 8'h00);
    z80_read("fifo_rd5", 8'h04, 2);
    check_eq("fifo_rd5_dout", z80_dout, 8'h04);
`else
    check_eq("latch_dout", z80_dout, 8'h05);
    z80_read("latch_rd", 8'h05, 2);
    check_eq("latch_empty", 8'(cmd_pending), 8'h00);
`endif
    check_eq("ovr_sticky", 8'(overrun), 8'h01);

    // reset in the middle of a Z80 read with 0x77 pending
    m68k_write(8'h77, 2);
    check_eq("pre_rst_dout", z80_dout, 8'h77);
    @(negedge clk);
    z80_latch_cs = 1'b1; z80_rd_n = 1'b0;
    repeat (2) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    check_eq("arst_pending", 8'(cmd_pending), 8'h00);
    check_eq("arst_int_n", 8'(z80_int_n), 8'h01);
    check_eq("arst_dout", z80_dout, 8'h00);
    check_eq("arst_overrun", 8'(overrun), 8'h00);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    m68k_write(8'h44, 2);
    check_eq("post_rst_pending", 8'(cmd_pending), 8'h01);
    z80_latch_cs = 1'b0; z80_rd_n = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("no_evt_pending", 8'(cmd_pending), 8'h01);
    check_eq("no_evt_dout", z80_dout, 8'h44);
    z80_read("post_rst_rd", 8'h44, 2);
    check_eq("post_rst_drain", 8'(cmd_pending), 8'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
